bus_slave_ctrl: RTL

BUS_SLAVE_CTRL -- requirements
Module: bus_slave_ctrl

---
 rtl/bus_slave_pkg.sv | 19 +
 rtl/bus_slave_if.sv | 40 ++++
 rtl/slave_regfile.sv | 58 +++++
 rtl/bus_slave_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bus_slave_pkg.sv
// Shared definitions for the bus slave controller.
//   state_e  : FSM state encoding (IDLE, WAIT, DONE), also exported as debug state
//   ERR_DATA : read data returned on any errored transaction
//   DATA_W   : bus / register data width
//   CNT_W    : width of the wait-state counter
package bus_slave_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bus_slave_if.sv
// Bus between a master, the slave controller and a downstream wait-state
// generator.
//   SEL, WRITE, ADDR, WDATA   : master request (held stable while SEL=1)
//   RDATA, BUS_READY, BUS_ERR : slave completion; RDATA/BUS_ERR qualified by BUS_READY
//   STROBE, WAIT_READY        : slave <-> wait-state generator handshake
//
// Handshake: the master raises SEL with WRITE/ADDR/WDATA and holds them until it
// samples BUS_READY=1 on a rising edge; BUS_READY is a one-cycle pulse and
// RDATA/BUS_ERR are meaningful only in that cycle. The slave holds STROBE high
// until it samples WAIT_READY=1 (or gives up); WAIT_READY is ignored while
// STROBE is low.
interface bus_slave_if;
    import bus_slave_pkg::*;

    logic              SEL;
    logic              WRITE;
    logic [DATA_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W-1:0] RDATA;
    logic              BUS_READY;
    logic              BUS_ERR;
    logic              STROBE;
    logic              WAIT_READY;

    modport slave (
        input  SEL, WRITE, ADDR, WDATA, WAIT_READY,
        output RDATA, BUS_READY, BUS_ERR, STROBE
    );

    modport master (
        output SEL, WRITE, ADDR, WDATA,
        input  RDATA, BUS_READY, BUS_ERR
    );

    modport waitgen (
        input  STROBE,
        output WAIT_READY
    );

endinterface

// File: rtl/slave_regfile.sv
// Register array plus completed-transaction counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   we_i, widx_i, wdata_i : write port (index NREGS-1 is read-only and ignored)
//   ridx_i, rdata_o       : combinational read port; index NREGS-1 reads the counter
//   inc_i                 : increment the transaction counter (wraps at 2^32)
module slave_regfile
    import bus_slave_pkg::*;
#(
    parameter  int NREGS = 8,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              inc_i
);

    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NREGS - 1);

    // Entry NREGS-1 of the array is never written; the counter stands in for it.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (we_i && (widx_i != CNT_IDX)) begin
                regs_q[widx_i] <= wdata_i;
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (ridx_i == CNT_IDX) begin
            rdata_o = cnt_q;
        end else begin
            rdata_o = regs_q[ridx_i];
        end
    end

endmodule

// File: rtl/bus_slave_ctrl.sv
// Bus slave controller: accepts a single-beat request, runs a STROBE/WAIT_READY
// handshake with a wait-state generator, then accesses the register file and
// returns a one-cycle BUS_READY pulse with BUS_ERR/RDATA.
//   CLK, RESETn : clock, asynchronous active-low reset
//   bus         : bus_slave_if slave modport (request, completion, wait handshake)
//   state_o     : current FSM state, for observation
module bus_slave_ctrl
    import bus_slave_pkg::*;
#(
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESETn,
    bus_slave_if.slave  bus,
    output state_e      state_o
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [IDX_W-1:0] CNT_IDX   = IDX_W'(NREGS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic              write_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              strobe_q;
    logic              ready_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    // Request decode: word-aligned and no address bit above the index field.
    logic             addr_ok;
    logic [IDX_W-1:0] addr_idx;

    assign addr_idx = bus.ADDR[IDX_W+1:2];
    assign addr_ok  = (bus.ADDR[1:0] == 2'b00) && ((bus.ADDR >> (IDX_W + 2)) == '0);

    // The access happens on the edge that leaves WAIT via WAIT_READY. A write to
    // the counter slot completes the handshake but is turned into an error.
    logic wait_done;
    logic ro_write;
    logic do_write;
    logic do_inc;
    logic [DATA_W-1:0] rf_rdata;

    assign wait_done = (state_q == ST_WAIT) && bus.WAIT_READY;
    assign ro_write  = write_q && (idx_q == CNT_IDX);
    assign do_write  = wait_done && write_q && !ro_write;
    assign do_inc    = wait_done && !ro_write;

    slave_regfile #(.NREGS(NREGS)) u_regs (
        .clk_i   (CLK),
        .rst_ni  (RESETn),
        .we_i    (do_write),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .ridx_i  (idx_q),
        .rdata_o (rf_rdata),
        .inc_i   (do_inc)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            strobe_q   <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            // BUS_READY/BUS_ERR are only ever set on the edge entering DONE.
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.SEL) begin
                        write_q    <= bus.WRITE;
                        idx_q      <= addr_idx;
                        wdata_q    <= bus.WDATA;
                        wait_cnt_q <= '0;
                        if (addr_ok) begin
                            strobe_q <= 1'b1;
                            state_q  <= ST_WAIT;
                        end else begin
                            ready_q  <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= ERR_DATA;
                            state_q  <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    // SEL is deliberately not looked at here: once started, a
                    // transaction always runs to completion.
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (bus.WAIT_READY) begin
                        // WAIT_READY wins over a timeout reached in the same cycle.
                        strobe_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= ST_DONE;
                        if (ro_write) begin
                            err_q   <= 1'b1;
                            rdata_q <= ERR_DATA;
                        end else if (!write_q) begin
                            rdata_q <= rf_rdata;
                        end
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        strobe_q <= 1'b0;
                        ready_q  <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= ERR_DATA;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    strobe_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.RDATA     = rdata_q;
    assign bus.BUS_READY = ready_q;
    assign bus.BUS_ERR   = err_q;
    assign bus.STROBE    = strobe_q;
    assign state_o       = state_q;

endmodule
